// File: rtl/guess_game_pkg.sv
// Shared types and helpers for the word-guessing game controller.
// Holds the state encoding and the lives-to-thermometer conversion.
package guess_game_pkg;

   typedef enum logic [2:0] {
      ST_SETUP = 3'd0,
      ST_PLAY  = 3'd1,
      ST_WIN   = 3'd2,
      ST_LOSS  = 3'd3
   } state_e;

   // Lives counter is sized for the largest supported budget.
   localparam int MAX_LIVES_LIM = 16;
   localparam int LIVES_W       = $clog2(MAX_LIVES_LIM + 1);

   function automatic logic [MAX_LIVES_LIM-1:0] thermo(input logic [LIVES_W-1:0] lives);
      logic [MAX_LIVES_LIM-1:0] t;
      for (int i = 0; i < MAX_LIVES_LIM; i++) begin
         t[i] = (LIVES_W'(i) < lives);
      end
      return t;
   endfunction

endpackage

// File: rtl/guess_game_if.sv
// Player-facing bundle: switch/key inputs and the display/LED outputs.
interface guess_game_if #(
   parameter int SYM_W     = 5,
   parameter int WORD_LEN  = 5,
   parameter int MAX_LIVES = 6
);
   logic [SYM_W-1:0]          sym_in;
   logic                      enter_n;
   logic                      restart_n;
   logic [WORD_LEN*SYM_W-1:0] disp_word;
   logic [MAX_LIVES-1:0]      lives_led;
   logic [2:0]                state_o;
   logic                      win;
   logic                      loss;
   logic [7:0]                win_cnt;

   modport slave (
      input  sym_in, enter_n, restart_n,
      output disp_word, lives_led, state_o, win, loss, win_cnt
   );

   modport master (
      output sym_in, enter_n, restart_n,
      input  disp_word, lives_led, state_o, win, loss, win_cnt
   );
endinterface

// File: rtl/guess_game_key_press_det.sv
// Two-flop synchroniser for an active-low key plus a one-cycle press pulse
// on the released-to-pressed transition.
module key_press_det (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   always_comb begin
      sync1_d = key_n;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Flops come out of reset as a released key so no spurious press appears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign press = prev_q & ~sync2_q;
endmodule

// File: rtl/guess_game_ctrl.sv
// Word-guessing game controller: secret entry, guessing with a miss budget,
// and blinking win/loss displays with a saturating win counter.
module guess_game_ctrl
   import guess_game_pkg::*;
#(
   parameter int SYM_W     = 5,
   parameter int WORD_LEN  = 5,
   parameter int MAX_LIVES = 6,
   parameter int BLINK_CYC = 5000000,
   parameter logic [WORD_LEN*SYM_W-1:0] LOSS_PAT = {5'd0, 5'd6, 5'd18, 5'd16, 5'd12}
) (
   input logic         clk,
   input logic         rst,
   guess_game_if.slave bus
);
   localparam int W     = WORD_LEN * SYM_W;
   localparam int IDX_W = $clog2(WORD_LEN + 1);
   localparam int TMR_W = $clog2(BLINK_CYC);
   localparam logic [IDX_W-1:0]   IDX_FULL   = IDX_W'(WORD_LEN);
   localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(MAX_LIVES);
   localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(BLINK_CYC - 1);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [W-1:0]         letters_q, letters_d;
   logic [W-1:0]         disp_q, disp_d;
   logic [WORD_LEN-1:0]  mask_q, mask_d;
   logic [LIVES_W-1:0]   lives_q, lives_d;
   logic [MAX_LIVES-1:0] lives_led_q, lives_led_d;
   logic                 win_q, win_d;
   logic                 loss_q, loss_d;
   logic [7:0]           win_cnt_q, win_cnt_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 phase_q, phase_d;

   logic                 press;
   logic                 sym_nz;
   logic                 do_restart;
   logic [WORD_LEN-1:0]  match;
   logic [WORD_LEN-1:0]  new_mask;
   logic [W-1:0]         reveal_word;

   key_press_det u_enter (
      .clk   (clk),
      .rst   (rst),
      .key_n (bus.enter_n),
      .press (press)
   );

   assign sym_nz   = |bus.sym_in;
   assign new_mask = mask_q | match;

   generate
      for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_slot
         assign match[gi]                         = (letters_q[gi*SYM_W +: SYM_W] == bus.sym_in);
         assign reveal_word[gi*SYM_W +: SYM_W]    = new_mask[gi] ? letters_q[gi*SYM_W +: SYM_W] : '0;
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      letters_d  = letters_q;
      disp_d     = disp_q;
      mask_d     = mask_q;
      lives_d    = lives_q;
      win_d      = win_q;
      loss_d     = loss_q;
      win_cnt_d  = win_cnt_q;
      timer_d    = timer_q;
      phase_d    = phase_q;
      do_restart = 1'b0;

      case (state_q)
         ST_SETUP: begin
            if (press) begin
               if (idx_q == IDX_FULL) begin
                  disp_d  = '0;
                  mask_d  = '0;
                  state_d = ST_PLAY;
               end else if (sym_nz) begin
                  for (int i = 0; i < WORD_LEN; i++) begin
                     if (idx_q == IDX_W'(i)) begin
                        letters_d[i*SYM_W +: SYM_W] = bus.sym_in;
                        disp_d[i*SYM_W +: SYM_W]    = bus.sym_in;
                     end
                  end
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         ST_PLAY: begin
            // A full reveal wins before any miss accounting is considered.
            if (press && sym_nz) begin
               if (&new_mask) begin
                  state_d   = ST_WIN;
                  win_d     = 1'b1;
                  mask_d    = new_mask;
                  disp_d    = reveal_word;
                  win_cnt_d = (win_cnt_q == 8'hFF) ? win_cnt_q : win_cnt_q + 8'd1;
                  timer_d   = '0;
                  phase_d   = 1'b0;
               end else if (match == '0) begin
                  lives_d = lives_q - 1'b1;
                  if (lives_q == LIVES_W'(1)) begin
                     state_d = ST_LOSS;
                     loss_d  = 1'b1;
                     disp_d  = LOSS_PAT;
                     timer_d = '0;
                     phase_d = 1'b0;
                  end
               end else begin
                  mask_d = new_mask;
                  disp_d = reveal_word;
               end
            end
         end

         ST_WIN, ST_LOSS: begin
            if (press && !bus.restart_n) begin
               do_restart = 1'b1;
            end else begin
               if (timer_q == TMR_LAST) begin
                  timer_d = '0;
                  phase_d = ~phase_q;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
               if (state_q == ST_WIN) begin
                  disp_d = phase_d ? '0 : letters_q;
               end else begin
                  disp_d = phase_d ? letters_q : LOSS_PAT;
               end
            end
         end

         default: do_restart = 1'b1;
      endcase

      // New round: everything except the win tally goes back to its reset value.
      if (do_restart) begin
         state_d   = ST_SETUP;
         idx_d     = '0;
         letters_d = '0;
         mask_d    = '0;
         lives_d   = LIVES_FULL;
         disp_d    = '0;
         timer_d   = '0;
         phase_d   = 1'b0;
         win_d     = 1'b0;
         loss_d    = 1'b0;
      end

      lives_led_d = MAX_LIVES'(thermo(lives_d));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SETUP;
         idx_q       <= '0;
         letters_q   <= '0;
         disp_q      <= '0;
         mask_q      <= '0;
         lives_q     <= LIVES_FULL;
         lives_led_q <= '1;
         win_q       <= 1'b0;
         loss_q      <= 1'b0;
         win_cnt_q   <= '0;
         timer_q     <= '0;
         phase_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         letters_q   <= letters_d;
         disp_q      <= disp_d;
         mask_q      <= mask_d;
         lives_q     <= lives_d;
         lives_led_q <= lives_led_d;
         win_q       <= win_d;
         loss_q      <= loss_d;
         win_cnt_q   <= win_cnt_d;
         timer_q     <= timer_d;
         phase_q     <= phase_d;
      end
   end

   assign bus.disp_word = disp_q;
   assign bus.lives_led = lives_led_q;
   assign bus.state_o   = state_q;
   assign bus.win       = win_q;
   assign bus.loss      = loss_q;
   assign bus.win_cnt   = win_cnt_q;
endmodule

// File: tb/tb_guess_game_ctrl.sv
// Randomised bench for guess_game_ctrl against a rule-level game model.
module tb_guess_game_ctrl;
   localparam int SW    = 5;
   localparam int WL    = 5;
   localparam int ML    = 6;
   localparam int BLINK = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   guess_game_if #(.SYM_W(SW), .WORD_LEN(WL), .MAX_LIVES(ML)) bus ();

   guess_game_ctrl #(
      .SYM_W(SW), .WORD_LEN(WL), .MAX_LIVES(ML), .BLINK_CYC(BLINK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Game model: state 0 setup, 1 play, 2 won, 3 lost.
   int m_state, m_idx, m_lives, m_wins, entry_cyc;
   int m_word[WL];
   bit m_rev[WL];
   int loss_sym[WL] = '{12, 16, 18, 6, 0};

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_new_round();
      m_state = 0;
      m_idx   = 0;
      m_lives = ML;
      for (int i = 0; i < WL; i++) begin
         m_word[i] = 0;
         m_rev[i]  = 1'b0;
      end
   endtask

   task automatic model_press(input int sym, input bit rs_n);
      bit hit, all;
      case (m_state)
         0: begin
            if (m_idx == WL) begin
               m_state = 1;
               for (int i = 0; i < WL; i++) m_rev[i] = 1'b0;
            end else if (sym != 0) begin
               m_word[m_idx] = sym;
               m_idx++;
            end
         end
         1: begin
            if (sym != 0) begin
               hit = 1'b0;
               all = 1'b1;
               for (int i = 0; i < WL; i++) begin
                  if (m_word[i] == sym) begin
                     hit      = 1'b1;
                     m_rev[i] = 1'b1;
                  end
                  all = all & m_rev[i];
               end
               if (all) begin
                  m_state   = 2;
                  m_wins    = (m_wins < 255) ? m_wins + 1 : 255;
                  entry_cyc = cyc;
               end else if (!hit) begin
                  m_lives--;
                  if (m_lives == 0) begin
                     m_state   = 3;
                     entry_cyc = cyc;
                  end
               end
            end
         end
         default: if (!rs_n) model_new_round();
      endcase
   endtask

   function automatic logic [WL*SW-1:0] exp_disp();
      logic [WL*SW-1:0] d;
      int ph;
      d  = '0;
      ph = ((cyc - entry_cyc) / BLINK) % 2;
      for (int i = 0; i < WL; i++) begin
         case (m_state)
            0:       d[i*SW +: SW] = SW'(m_word[i]);
            1:       d[i*SW +: SW] = m_rev[i] ? SW'(m_word[i]) : '0;
            2:       d[i*SW +: SW] = (ph == 1) ? '0 : SW'(m_word[i]);
            default: d[i*SW +: SW] = (ph == 1) ? SW'(m_word[i]) : SW'(loss_sym[i]);
         endcase
      end
      return d;
   endfunction

   task automatic check_all(input string tag);
      check_eq({tag, ".state"}, 64'(bus.state_o), 64'(m_state));
      check_eq({tag, ".disp"},  64'(bus.disp_word), 64'(exp_disp()));
      check_eq({tag, ".lives"}, 64'(bus.lives_led), 64'((1 << m_lives) - 1));
      check_eq({tag, ".win"},   64'(bus.win), 64'(m_state == 2));
      check_eq({tag, ".loss"},  64'(bus.loss), 64'(m_state == 3));
      check_eq({tag, ".wcnt"},  64'(bus.win_cnt), 64'(m_wins));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         check_all("idle");
      end
   endtask

   // Outputs must hold for two edges after the key falls and update on the third.
   task automatic press(input int sym, input bit rs_n);
      @(negedge clk);
      bus.sym_in    = SW'(sym);
      bus.restart_n = rs_n;
      bus.enter_n   = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check_all("pre");
      end
      @(negedge clk);
      model_press(sym, rs_n);
      check_all("press");
      $display("press sym=%0d restart_n=%0d -> state=%0d disp=%h lives=%b wins=%0d",
               sym, rs_n, bus.state_o, bus.disp_word, bus.lives_led, bus.win_cnt);
      bus.enter_n = 1'b1;
      idle(3);
   endtask

   initial begin
      int w[WL];
      bus.sym_in    = '0;
      bus.enter_n   = 1'b1;
      bus.restart_n = 1'b1;
      m_wins        = 0;
      entry_cyc     = 0;
      model_new_round();

      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b0;
      idle(2);

      // Directed: setup, repeat guess, six misses to a loss.
      w = '{3, 7, 3, 9, 1};
      for (int i = 0; i < WL; i++) press(w[i], 1'b1);
      press(0, 1'b1);
      press(3, 1'b1);
      press(3, 1'b1);
      for (int i = 0; i < ML; i++) press(5, 1'b1);
      idle(12);
      press(2, 1'b1);
      press(0, 1'b0);

      // Directed: win then ignored press then restart.
      for (int i = 0; i < WL; i++) press(w[i], 1'b1);
      press(0, 1'b0);
      press(3, 1'b0);
      press(7, 1'b1);
      press(9, 1'b1);
      press(1, 1'b1);
      idle(11);
      press(6, 1'b1);
      press(0, 1'b0);

      // Held key gives one press; a blank symbol press is ignored.
      @(negedge clk);
      bus.sym_in  = SW'(4);
      bus.enter_n = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 3) model_press(4, 1'b1);
         check_all("hold");
      end
      bus.enter_n = 1'b1;
      idle(3);
      press(0, 1'b1);
      for (int i = 1; i < WL; i++) press($urandom_range(1, 9), 1'b1);
      press(0, 1'b1);
      for (int g = 0; g < 40 && m_state == 1; g++) press($urandom_range(0, 9), 1'($urandom_range(0, 1)));
      if (m_state >= 2) press(0, 1'b0);

      // Randomised games.
      for (int game = 0; game < 6; game++) begin
         for (int i = 0; i < WL + 2; i++) press($urandom_range(0, 9), 1'($urandom_range(0, 1)));
         press(0, 1'b1);
         for (int g = 0; g < 40 && m_state == 1; g++) press($urandom_range(0, 9), 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 12));
         press($urandom_range(0, 9), 1'b1);
         press($urandom_range(0, 9), 1'b0);
      end

      // Asynchronous reset in the middle of a game.
      for (int i = 0; i < WL; i++) press(w[i], 1'b1);
      press(0, 1'b1);
      press(3, 1'b1);
      press(8, 1'b1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      m_wins = 0;
      model_new_round();
      check_all("async_rst");
      @(posedge clk);
      #3 rst = 1'b0;
      idle(2);
      press(2, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/guess_game_ctrl.md
Name: guess_game_ctrl

Overview:
- Parametrised word-guessing game controller: player 1 enters a secret word of WORD_LEN symbols, player 2 guesses symbols, with a MAX_LIVES miss budget.
- Successor to the fixed 5-letter / 6-life controller. Adds:
  - parametrised word length, symbol width, lives and blink period;
  - no life lost for repeated guesses;
  - distinct win and loss states;
  - a saturating win counter.
- Sits between the switch/key inputs and the per-digit seven-segment decoders; it drives a packed display bus and the life LEDs.

Parameters:
- SYM_W, 5: symbol width in bits. Value 0 means blank / no symbol. Minimum 2.
- WORD_LEN, 5: symbols per secret word, 1..8.
- MAX_LIVES, 6: misses allowed, 1..16.
- BLINK_CYC, 5000000: cycles per blink half-period in WIN/LOSS; at least 2.
- LOSS_PAT, {12,16,18,6,0} (packed, index 0 first): display pattern shown on loss; WORD_LEN*SYM_W bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sym_in  in  SYM_W  symbol switches
- enter_n  in  1  active-low pushbutton; a press = falling edge
- restart_n  in  1  active-low switch; qualifies a press as restart
- disp_word  out  WORD_LEN*SYM_W  symbol for each digit (slot i at bits [i*SYM_W +: SYM_W]); 0 = blank
- lives_led  out  MAX_LIVES  thermometer; bit i = 1 iff i < lives remaining
- state_o  out  3  current state encoding
- win  out  1  high in WIN
- loss  out  1  high in LOSS
- win_cnt  out  8  rounds won; saturates at 255

Behaviour:
- Reset (async, rst=1), all outputs registered:
  - state=SETUP; idx=0; letters=0; reveal mask=0; disp_word=0.
  - lives=MAX_LIVES, so lives_led=all ones.
  - win=0, loss=0, win_cnt=0, blink timer=0, phase=0.
  - Synchroniser and previous-sample flops reset to 1 (released key).
- Press detection:
  - enter_n passes through a 2-flop synchroniser.
  - press = prev & ~sync, a one-cycle pulse.
  - Press-to-output latency: outputs change 3 clk edges after enter_n falls.
  - Holding the key produces exactly one press.
- SETUP:
  - Press with sym_in!=0 and idx<WORD_LEN: letter[idx]<=sym_in, disp slot idx<=sym_in, idx++.
  - Press with sym_in==0: ignored.
  - Press with idx==WORD_LEN (confirm press): disp_word<=0, mask<=0, go to PLAY.
- PLAY, press with sym_in!=0:
  - match[i] = (letter[i]==sym_in).
  - newmask = mask | match. Display shows letter[i] where newmask[i], else 0.
  - If newmask is all ones: go to WIN, win_cnt++ (saturating).
  - Else if match==0 (a miss): lives--. If lives becomes 0, go to LOSS.
  - If match!=0 but every matched slot was already revealed (repeat guess): no change, no life lost.
  - A press with sym_in==0 is ignored.
  - Win is checked before miss; both cannot occur together.
- WIN:
  - disp_word alternates word / blank.
  - Phase toggles each time the timer reaches BLINK_CYC-1, then the timer wraps to 0.
  - Phase 0 = shown; entry sets timer=0, phase=0.
- LOSS:
  - disp_word alternates LOSS_PAT / full word with the same timer rules.
  - lives_led=0.
- Restart:
  - Only in WIN/LOSS: a press with restart_n==0 returns to SETUP with idx=0, letters=0, mask=0, lives=MAX_LIVES, display=0, timer=0.
  - win_cnt is kept.
  - A press with restart_n==1 in WIN/LOSS is ignored.
  - restart_n is ignored in SETUP/PLAY.
- rst asserted mid-game restores the reset values immediately, in any state.
- State encoding: SETUP=0, PLAY=1, WIN=2, LOSS=3. Other codes are unreachable and recover to SETUP.

Decomposition:
- Package guess_game_pkg holds:
  - state enum and encodings;
  - function thermo(lives) returning the MAX_LIVES-bit thermometer;
  - localparam LIVES_W = $clog2(MAX_LIVES+1).
- One sub-module, key_press_det: 2-flop synchroniser plus falling-edge pulse. It is used for enter_n.

Test Plan:
- Reset, then setup with word {3,7,3,9,1} (5 presses plus a confirm press) -> disp_word shows each symbol after its press, then all zero; state_o=1; lives_led=6'b111111.
- In PLAY, press 3 -> slots 0 and 2 show 3, lives unchanged. Press 3 again -> no change; lives_led stays 6'b111111.
- In PLAY, press 5 six times -> lives_led goes 011111, 001111, … 000000. After the sixth press state_o=3 and loss=1. Display alternates LOSS_PAT / word every BLINK_CYC cycles (BLINK_CYC=4 in bench).
- Guess 3, 7, 9, 1 -> after the 4th press state_o=2, win=1, win_cnt=1, display blinks the word. Press with restart_n=0 -> state_o=0, display 0, lives full, win_cnt remains 1.
- Hold enter_n low for 100 cycles in SETUP with sym_in=4 -> exactly one symbol stored (idx=1). A press with sym_in=0 -> idx unchanged.
- Assert rst mid-PLAY for 1 cycle, asynchronous to clk -> all outputs return to reset values before the next clk edge. win_cnt=0.
